serial_fft_sched: RTL and testbench

Frame scheduler that sits in front of serial_fft_coral-style serial DFT cores.
- Buffers one input frame of FRAME_LENGTH multi-channel samples.
- Replays the frame once per DFT bin k = 0..BINS-1, driving core valid and data, plus a twiddle index (k·n mod FRAME_LENGTH) to an external W ROM.
- Captures each bin's accumulated re/im result and presents it on a valid/ready output with its bin number.

---
 rtl/serial_fft_sched_if.sv | 29 ++
 rtl/serial_fft_sched.sv | 179 +++++++++++++++++
 tb/tb_serial_fft_sched.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_fft_sched_if.sv
// Stream interface of serial_fft_sched: sample input (s_*) and bin result output (m_*).
// slave  : the scheduler side
// master : the sample producer / result consumer side
interface serial_fft_sched_if #(
    parameter int X_WIDTH = 16,
    parameter int S_WIDTH = 32,
    parameter int BINS    = 8,
    parameter int CHANELS = 2
);
    logic                         s_valid;
    logic                         s_ready;
    logic [CHANELS*X_WIDTH-1:0]   s_data;
    logic                         m_valid;
    logic                         m_ready;
    logic [$clog2(BINS)-1:0]      m_bin;
    logic                         m_last;
    logic [CHANELS*S_WIDTH-1:0]   m_re;
    logic [CHANELS*S_WIDTH-1:0]   m_im;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_bin, m_last, m_re, m_im
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_bin, m_last, m_re, m_im
    );
endinterface

// File: rtl/serial_fft_sched.sv
// Frame scheduler for a serial DFT core: buffers one frame, replays it once per
// bin with the matching twiddle ROM address, and captures each bin result.
// Optional build macro SERIAL_FFT_SCHED_CHECK_EN adds the sticky err output that
// flags a core_counter / sample index disagreement on any issuing cycle.
//
// state | meaning
// IDLE  | one cycle after reset before accepting samples
// LOAD  | s_ready high, frame samples written to mem
// RUN   | frame replayed to the core, one pass per bin
// DRAIN | waiting for the final bin result to be captured
module serial_fft_sched #(
    parameter int X_WIDTH      = 16,
    parameter int S_WIDTH      = 32,
    parameter int FRAME_LENGTH = 8,
    parameter int BINS         = 8,
    parameter int CHANELS      = 2
) (
    input  logic                                clk,
    input  logic                                rstn,
    serial_fft_sched_if.slave                   sif,
    output logic                                core_valid,
    output logic [CHANELS*X_WIDTH-1:0]          core_x,
    output logic [$clog2(FRAME_LENGTH)-1:0]     tw_idx,
    input  logic [$clog2(FRAME_LENGTH)-1:0]     core_counter,
    input  logic [CHANELS*S_WIDTH-1:0]          core_re,
    input  logic [CHANELS*S_WIDTH-1:0]          core_im
`ifdef SERIAL_FFT_SCHED_CHECK_EN
    ,
    output logic                                err
`endif
);
    localparam int NW = $clog2(FRAME_LENGTH);
    localparam int BW = $clog2(BINS);
    localparam logic [NW-1:0] N_LAST = NW'(FRAME_LENGTH - 1);
    localparam logic [BW-1:0] K_LAST = BW'(BINS - 1);
    localparam logic [NW:0]   N_FULL = (NW + 1)'(FRAME_LENGTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t                      state_q;
    logic [NW-1:0]               n_q;
    logic [NW-1:0]               acc_q;
    logic [NW-1:0]               acc_d;
    logic [NW:0]                 acc_sum;
    logic [BW-1:0]               k_q;
    logic [CHANELS*X_WIDTH-1:0]  mem_q [FRAME_LENGTH];
    logic                        cap_q;
    logic [BW-1:0]               cap_bin_q;
    logic                        cap_last_q;
    logic                        m_valid_q;
    logic [BW-1:0]               m_bin_q;
    logic                        m_last_q;
    logic [CHANELS*S_WIDTH-1:0]  m_re_q;
    logic [CHANELS*S_WIDTH-1:0]  m_im_q;
    logic                        last_n;
    logic                        issue;
    logic                        beat;

    // The final sample of a bin may only go out when the result slot will be free
    // by the time its capture lands; earlier samples never wait.
    assign last_n = (n_q == N_LAST);
    assign issue  = (state_q == RUN) && (!last_n || !m_valid_q || sif.m_ready);
    assign beat   = (state_q == LOAD) && sif.s_valid;

    assign sif.s_ready = (state_q == LOAD);
    assign core_valid  = issue;
    assign core_x      = issue ? mem_q[n_q] : '0;
    assign tw_idx      = issue ? acc_q : '0;
    assign sif.m_valid = m_valid_q;
    assign sif.m_bin   = m_bin_q;
    assign sif.m_last  = m_last_q;
    assign sif.m_re    = m_re_q;
    assign sif.m_im    = m_im_q;

    // Twiddle address steps by k modulo N; acc+k < 2N so one conditional subtract suffices.
    always_comb begin
        acc_sum = {1'b0, acc_q} + {{(NW + 1 - BW){1'b0}}, k_q};
        if (acc_sum >= N_FULL) begin
            acc_sum = acc_sum - N_FULL;
        end
        acc_d = acc_sum[NW-1:0];
    end

    // Frame buffer, deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (beat) begin
            mem_q[n_q] <= sif.s_data;
        end
    end

    // Sequencer FSM with result capture two cycles after a bin's last sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            n_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            cap_q      <= 1'b0;
            cap_bin_q  <= '0;
            cap_last_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_bin_q    <= '0;
            m_last_q   <= 1'b0;
            m_re_q     <= '0;
            m_im_q     <= '0;
        end else begin
            cap_q      <= issue && last_n;
            cap_bin_q  <= k_q;
            cap_last_q <= (k_q == K_LAST);

            if (cap_q) begin
                m_valid_q <= 1'b1;
                m_bin_q   <= cap_bin_q;
                m_last_q  <= cap_last_q;
                m_re_q    <= core_re;
                m_im_q    <= core_im;
            end else if (m_valid_q && sif.m_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: state_q <= LOAD;
                LOAD: begin
                    if (beat) begin
                        if (last_n) begin
                            n_q     <= '0;
                            k_q     <= '0;
                            acc_q   <= '0;
                            state_q <= RUN;
                        end else begin
                            n_q <= n_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (last_n) begin
                            n_q   <= '0;
                            acc_q <= '0;
                            if (k_q == K_LAST) begin
                                state_q <= DRAIN;
                            end else begin
                                k_q <= k_q + 1'b1;
                            end
                        end else begin
                            n_q   <= n_q + 1'b1;
                            acc_q <= acc_d;
                        end
                    end
                end
                DRAIN: begin
                    // cap_q is high on the first DRAIN cycle; leave once it has landed.
                    if (!cap_q) begin
                        state_q <= LOAD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SERIAL_FFT_SCHED_CHECK_EN
    logic err_q;
    assign err = err_q;

    // Sticky alignment monitor: the core's sample counter must track n on every issue.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (issue && (core_counter != n_q)) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_core_counter;
    assign unused_core_counter = ^core_counter;
`endif

endmodule

// File: tb/tb_serial_fft_sched.sv
// Bench for serial_fft_sched with N=4, BINS=4, one channel. A behavioural serial
// DFT core and its twiddle ROM sit beside the DUT; expected bin results come from
// a direct DFT of each frame pushed into a queue.
module tb_serial_fft_sched;
    localparam int N  = 4;
    localparam int NB = 4;

    typedef struct {
        int bin;
        bit last;
        int re;
        int im;
    } res_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        core_valid;
    logic [15:0] core_x;
    logic [1:0]  tw_idx;
    logic [1:0]  core_counter;
    logic [31:0] core_re;
    logic [31:0] core_im;
    logic [1:0]  core_cnt;
    int          acc_re;
    int          acc_im;
    logic        ovr_en = 1'b0;
`ifdef SERIAL_FFT_SCHED_CHECK_EN
    logic        err;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   iss_cnt = 0;
    int   beat_cnt = 0;
    bit   err_armed = 1'b0;
    int   wre[4] = '{1, 0, -1, 0};
    int   wim[4] = '{0, -1, 0, 1};
    int   frame_m[4];
    res_t exp_q[$];
    res_t res_log[$];
    int   tw_log[$];
    int   cn, ck;
    res_t ce;

    serial_fft_sched_if #(.X_WIDTH(16), .S_WIDTH(32), .BINS(NB), .CHANELS(1)) sif ();

    serial_fft_sched #(
        .X_WIDTH(16), .S_WIDTH(32), .FRAME_LENGTH(N), .BINS(NB), .CHANELS(1)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .sif(sif),
        .core_valid(core_valid),
        .core_x(core_x),
        .tw_idx(tw_idx),
        .core_counter(core_counter),
        .core_re(core_re),
        .core_im(core_im)
`ifdef SERIAL_FFT_SCHED_CHECK_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    assign core_counter = ovr_en ? 2'd2 : core_cnt;

    // Serial DFT core: accumulates x*W over N valid samples, publishes the sum after the N-th.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_cnt <= 2'd0;
            acc_re   <= 0;
            acc_im   <= 0;
            core_re  <= '0;
            core_im  <= '0;
        end else if (core_valid) begin
            core_cnt <= core_cnt + 2'd1;
            if (core_cnt == 2'd3) begin
                core_re <= acc_re + int'($signed(core_x)) * wre[tw_idx];
                core_im <= acc_im + int'($signed(core_x)) * wim[tw_idx];
                acc_re  <= 0;
                acc_im  <= 0;
            end else begin
                acc_re <= acc_re + int'($signed(core_x)) * wre[tw_idx];
                acc_im <= acc_im + int'($signed(core_x)) * wim[tw_idx];
            end
        end
    end

    task automatic chk(input string nm, input bit ok, input longint act, input longint expv);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    // Expected results for one frame: direct DFT with the ROM above.
    task automatic push_model(input int xs[4]);
        res_t r;
        frame_m = xs;
        for (int k = 0; k < NB; k++) begin
            r.bin = k;
            r.last = (k == NB - 1);
            r.re = 0;
            r.im = 0;
            for (int n = 0; n < N; n++) begin
                r.re += xs[n] * wre[(k * n) % N];
                r.im += xs[n] * wim[(k * n) % N];
            end
            exp_q.push_back(r);
        end
    endtask

    // Cycle compare: issued sample/address against the replay schedule, results against the queue.
    always @(negedge clk) begin
        if (!rstn) begin
            exp_q.delete();
            iss_cnt = 0;
        end else begin
            if (sif.s_valid && sif.s_ready) beat_cnt++;
            if (core_valid) begin
                cn = iss_cnt % N;
                ck = (iss_cnt / N) % NB;
                chk("tw_idx", int'(tw_idx) == (ck * cn) % N, tw_idx, (ck * cn) % N);
                chk("core_x", int'($signed(core_x)) == frame_m[cn], $signed(core_x), frame_m[cn]);
                if (sif.s_ready) chk("s_ready_in_run", 1'b0, 1, 0);
                tw_log.push_back(int'(tw_idx));
                iss_cnt++;
            end
            if (sif.m_valid && sif.m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1'b0, sif.m_bin, -1);
                end else begin
                    ce = exp_q.pop_front();
                    chk("m_bin", int'(sif.m_bin) == ce.bin, sif.m_bin, ce.bin);
                    chk("m_last", sif.m_last == ce.last, sif.m_last, ce.last);
                    chk("m_re", int'($signed(sif.m_re)) == ce.re, $signed(sif.m_re), ce.re);
                    chk("m_im", int'($signed(sif.m_im)) == ce.im, $signed(sif.m_im), ce.im);
                end
                ce.bin = int'(sif.m_bin);
                ce.last = sif.m_last;
                ce.re = int'($signed(sif.m_re));
                ce.im = int'($signed(sif.m_im));
                res_log.push_back(ce);
            end
`ifdef SERIAL_FFT_SCHED_CHECK_EN
            if (!err_armed) chk("err_quiet", err == 1'b0, err, 0);
`endif
        end
    end

    task automatic send_frame(input int xs[4], input bit gap);
        int g;
        for (int i = 0; i < N; i++) begin
            g = 0;
            while (!sif.s_ready && g < 300) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 300) chk("s_ready_timeout", 1'b0, 0, 1);
            sif.s_valid = 1'b1;
            sif.s_data  = 16'(xs[i]);
            @(posedge clk); #1;
            sif.s_valid = 1'b0;
            sif.s_data  = 16'h5a5a;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_done();
        int g = 0;
        while (exp_q.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        chk("frame_done_timeout", exp_q.size() == 0, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, "_ctrl"}, {sif.s_ready, core_valid, sif.m_valid, sif.m_last, tw_idx, sif.m_bin} == 8'd0,
            {sif.s_ready, core_valid, sif.m_valid, sif.m_last, tw_idx, sif.m_bin}, 0);
        chk({tag, "_core_x"}, core_x == 16'd0, core_x, 0);
        chk({tag, "_m_re"}, sif.m_re == 32'd0, sif.m_re, 0);
        chk({tag, "_m_im"}, sif.m_im == 32'd0, sif.m_im, 0);
    endtask

    int f1[4];
    int f2[4];
    int ref_re[4] = '{10, -2, -2, -2};
    int ref_im[4] = '{0, 2, 0, -2};
    int tw_ref[16] = '{0, 0, 0, 0, 0, 1, 2, 3, 0, 2, 0, 2, 0, 3, 2, 1};
    int g;

    initial begin
        f1 = '{1, 2, 3, 4};
        f2 = '{4, 3, 2, 1};
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.m_ready = 1'b1;

        // Reset state and IDLE -> LOAD
        repeat (2) @(posedge clk);
        #1;
        check_zero_outs("reset");
        rstn = 1'b1;
        chk("idle_s_ready", sif.s_ready == 1'b0, sif.s_ready, 0);
        @(posedge clk); #1;
        chk("load_s_ready", sif.s_ready == 1'b1, sif.s_ready, 1);

        // Frame {1,2,3,4}: bin results and twiddle sequence
        res_log.delete();
        tw_log.delete();
        push_model(f1);
        send_frame(f1, 1'b0);
        wait_done();
        chk("t1_count", res_log.size() == 4, res_log.size(), 4);
        if (res_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("t1_bin_lit", res_log[i].bin == i, res_log[i].bin, i);
                chk("t1_re_lit", res_log[i].re == ref_re[i], res_log[i].re, ref_re[i]);
                chk("t1_im_lit", res_log[i].im == ref_im[i], res_log[i].im, ref_im[i]);
                chk("t1_last_lit", res_log[i].last == (i == 3), res_log[i].last, i == 3);
            end
        end
        chk("t2_tw_count", tw_log.size() == 16, tw_log.size(), 16);
        if (tw_log.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("t2_tw_lit", tw_log[i] == tw_ref[i], tw_log[i], tw_ref[i]);
        end

        // Output backpressure stalls the last sample of bin 1
        res_log.delete();
        sif.m_ready = 1'b0;
        push_model(f1);
        send_frame(f1, 1'b0);
        g = 0;
        while (!sif.m_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("t3_first_result", sif.m_valid == 1'b1, sif.m_valid, 1);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i >= 2) chk("t3_stall_core_valid", core_valid == 1'b0, core_valid, 0);
            chk("t3_hold_bin", sif.m_valid == 1'b1 && sif.m_bin == 2'd0, {sif.m_valid, sif.m_bin}, 4);
        end
        @(posedge clk); #1;
        sif.m_ready = 1'b1;
        wait_done();
        chk("t3_count", res_log.size() == 4, res_log.size(), 4);
        if (res_log.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t3_order", res_log[i].bin == i, res_log[i].bin, i);
            chk("t3_bin1_re", res_log[1].re == -2, res_log[1].re, -2);
            chk("t3_bin1_im", res_log[1].im == 2, res_log[1].im, 2);
        end

        // Sparse s_valid, and s_valid held high during RUN is ignored
        res_log.delete();
        beat_cnt = 0;
        push_model(f2);
        send_frame(f2, 1'b1);
        sif.s_valid = 1'b1;
        sif.s_data  = 16'h7777;
        repeat (10) @(posedge clk);
        #1;
        sif.s_valid = 1'b0;
        wait_done();
        chk("t4_beats", beat_cnt == 4, beat_cnt, 4);
        chk("t4_count", res_log.size() == 4, res_log.size(), 4);
        if (res_log.size() == 4) begin
            chk("t4_bin0_re", res_log[0].re == 10, res_log[0].re, 10);
            chk("t4_bin1_re", res_log[1].re == 2, res_log[1].re, 2);
            chk("t4_bin1_im", res_log[1].im == -2, res_log[1].im, -2);
        end

        // Reset in the middle of bin 2, sample 1
        push_model(f1);
        send_frame(f1, 1'b0);
        g = 0;
        while (g < 200) begin
            @(posedge clk); #2;
            if (core_valid && (iss_cnt % 16) == 9) break;
            g++;
        end
        chk("t5_reached_bin2", g < 200, g, 0);
        rstn = 1'b0;
        #1;
        check_zero_outs("t5_reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        chk("t5_idle", sif.s_ready == 1'b0 && core_valid == 1'b0, {sif.s_ready, core_valid}, 0);
        @(posedge clk); #1;
        chk("t5_load", sif.s_ready == 1'b1, sif.s_ready, 1);
        res_log.delete();
        push_model(f1);
        send_frame(f1, 1'b0);
        wait_done();
        chk("t5_count", res_log.size() == 4, res_log.size(), 4);
        if (res_log.size() == 4) begin
            chk("t5_bin0_re", res_log[0].re == 10, res_log[0].re, 10);
            chk("t5_bin3_im", res_log[3].im == -2, res_log[3].im, -2);
        end

`ifdef SERIAL_FFT_SCHED_CHECK_EN
        // Counter disagreement latches err until reset
        err_armed = 1'b1;
        push_model(f1);
        send_frame(f1, 1'b0);
        g = 0;
        while (g < 200) begin
            @(posedge clk); #2;
            if (core_valid && (iss_cnt % N) == 1) break;
            g++;
        end
        chk("t6_reached_n1", g < 200, g, 0);
        chk("t6_err_before", err == 1'b0, err, 0);
        ovr_en = 1'b1;
        @(posedge clk); #1;
        ovr_en = 1'b0;
        chk("t6_err_set", err == 1'b1, err, 1);
        wait_done();
        chk("t6_err_sticky", err == 1'b1, err, 1);
        rstn = 1'b0;
        #1;
        chk("t6_err_reset", err == 1'b0, err, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        err_armed = 1'b0;
        repeat (2) @(posedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
